// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation cycle controller and its display mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irrig_pkg;

  localparam int IRRIG_W = 4;

  // Mode encoding is also the select encoding of the downstream 2:1 display mux.
  localparam logic MODE_SPR  = 1'b0;
  localparam logic MODE_DRIP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_PAUSE    = 2'd2,
    ST_COOLDOWN = 2'd3
  } irrig_state_e;

endpackage

// File: rtl/irrigation_cycle_ctrl_if.sv
// Bundles the irrigation controller request inputs and valve/display outputs.
// Latency: n/a (wiring only).
// Backpressure: none; tick/start/abort are level or pulse inputs with no handshake.
// master: drives tick, start, mode, dur_spr, dur_drip, tank_low, abort; observes the rest.
// slave : the controller; drives spr_count, drip_count, disp_sel, valves, busy, done, cycles_done.
interface irrigation_cycle_ctrl_if
  import irrig_pkg::*;
#(
  parameter int W = IRRIG_W
);
  logic         tick;
  logic         start;
  logic         mode;
  logic [W-1:0] dur_spr;
  logic [W-1:0] dur_drip;
  logic         tank_low;
  logic         abort;
  logic [W-1:0] spr_count;
  logic [W-1:0] drip_count;
  logic         disp_sel;
  logic         valve_spr;
  logic         valve_drip;
  logic         busy;
  logic         done;
  logic [W-1:0] cycles_done;

  modport master (
    output tick, start, mode, dur_spr, dur_drip, tank_low, abort,
    input  spr_count, drip_count, disp_sel, valve_spr, valve_drip, busy, done, cycles_done
  );

  modport slave (
    input  tick, start, mode, dur_spr, dur_drip, tank_low, abort,
    output spr_count, drip_count, disp_sel, valve_spr, valve_drip, busy, done, cycles_done
  );
endinterface

// File: rtl/irrig_tick_counter.sv
// W-bit loadable down-counter stepped by a tick enable, with freeze, clear and zero flag.
// Latency: count updates on the clock edge where load/tick is sampled; zero_o follows the register.
// Backpressure: none; freeze_i simply suppresses ticks. Priority clear > load > tick.
// Ports: clk, rst_n, load_i/load_val_i, tick_i, freeze_i, clear_i -> cnt_o, zero_o.
module irrig_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  input  logic         freeze_i,
  input  logic         clear_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && !freeze_i && (cnt_q != '0)) begin
      // Saturates at zero rather than wrapping.
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/irrigation_cycle_ctrl.sv
// Runs one sprinkler or drip watering cycle counted in 1 s ticks, then a cooldown.
// Latency: valve opens one cycle after start is sampled; done pulses on the edge of the last tick.
// Backpressure: start is ignored outside IDLE; tank_low pauses the run, abort ends it at once.
// Ports: clk, rst_n (async, active-low); bus (irrigation_cycle_ctrl_if.slave) carries
//   tick/start/mode/dur_spr/dur_drip/tank_low/abort in and spr_count/drip_count/disp_sel/
//   valve_spr/valve_drip/busy/done/cycles_done out.
// Build option: define IRRIG_CYCLE_STATS_EN to enable the saturating completed-cycle counter;
//   otherwise cycles_done is tied to 0.
module irrigation_cycle_ctrl
  import irrig_pkg::*;
#(
  parameter int W              = IRRIG_W,
  parameter int COOLDOWN_TICKS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  irrigation_cycle_ctrl_if.slave bus
);
  irrig_state_e state_q, state_d;
  logic         disp_sel_q, disp_sel_d;
  logic         valve_spr_q, valve_spr_d;
  logic         valve_drip_q, valve_drip_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [W-1:0] dur_cnt, cool_cnt;
  logic         dur_zero, cool_zero;
  logic         dur_load, cool_load;
  logic         dur_freeze, cool_freeze;
  logic         run_done, zero_done;

  logic [W-1:0] dur_sel;
  logic         start_ok;

  assign dur_sel  = (bus.mode == MODE_DRIP) ? bus.dur_drip : bus.dur_spr;
  assign start_ok = bus.start && !bus.abort && !bus.tank_low;

  // State and output registers. Reset clears the valves asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      disp_sel_q   <= MODE_SPR;
      valve_spr_q  <= 1'b0;
      valve_drip_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_sel_q   <= disp_sel_d;
      valve_spr_q  <= valve_spr_d;
      valve_drip_q <= valve_drip_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic; abort > tank_low > tick > start in every state.
  always_comb begin
    state_d    = state_q;
    disp_sel_d = disp_sel_q;
    dur_load   = 1'b0;
    cool_load  = 1'b0;
    run_done   = 1'b0;
    zero_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          disp_sel_d = bus.mode;
          if (dur_sel != '0) begin
            dur_load = 1'b1;
            state_d  = ST_RUN;
          end else begin
            // Zero-length request completes on the spot without opening a valve.
            zero_done = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.tank_low) begin
          state_d = ST_PAUSE;
        end else if (dur_zero) begin
          // Unreachable in normal operation; recovers from a corrupted count.
          state_d = ST_IDLE;
        end else if (bus.tick && (dur_cnt == W'(1))) begin
          run_done  = 1'b1;
          cool_load = 1'b1;
          state_d   = ST_COOLDOWN;
        end
      end
      ST_PAUSE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!bus.tank_low) begin
          state_d = ST_RUN;
        end
      end
      ST_COOLDOWN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (cool_zero) begin
          state_d = ST_IDLE;
        end else if (bus.tick && (cool_cnt == W'(1))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the next state.
  always_comb begin
    valve_spr_d  = (state_d == ST_RUN) && (disp_sel_d == MODE_SPR);
    valve_drip_d = (state_d == ST_RUN) && (disp_sel_d == MODE_DRIP);
    busy_d       = (state_d != ST_IDLE);
    done_d       = run_done || zero_done;
  end

  // Duration counter only moves in RUN; a coincident tank_low wins over the tick.
  assign dur_freeze = (state_q != ST_RUN) || bus.tank_low;

  irrig_tick_counter #(.W(W)) u_dur_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (dur_load),
    .load_val_i (dur_sel),
    .tick_i     (bus.tick),
    .freeze_i   (dur_freeze),
    .clear_i    (bus.abort),
    .cnt_o      (dur_cnt),
    .zero_o     (dur_zero)
  );

  assign cool_freeze = (state_q != ST_COOLDOWN);

  irrig_tick_counter #(.W(W)) u_cool_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cool_load),
    .load_val_i (W'(COOLDOWN_TICKS)),
    .tick_i     (bus.tick),
    .freeze_i   (cool_freeze),
    .clear_i    (bus.abort),
    .cnt_o      (cool_cnt),
    .zero_o     (cool_zero)
  );

  // A single duration register serves both displays; the non-selected side is forced to 0
  // so the downstream mux can never show a stale value.
  assign bus.spr_count  = (disp_sel_q == MODE_SPR)  ? dur_cnt : '0;
  assign bus.drip_count = (disp_sel_q == MODE_DRIP) ? dur_cnt : '0;
  assign bus.disp_sel   = disp_sel_q;
  assign bus.valve_spr  = valve_spr_q;
  assign bus.valve_drip = valve_drip_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef IRRIG_CYCLE_STATS_EN
  logic [W-1:0] cycles_q;

  // Counts RUN completions only (not zero-length requests); saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
    end else if (run_done && (cycles_q != '1)) begin
      cycles_q <= cycles_q + 1'b1;
    end
  end

  assign bus.cycles_done = cycles_q;
`else
  assign bus.cycles_done = '0;
`endif
endmodule

// File: tb/tb_irrigation_cycle_ctrl.sv
// Directed bench for irrigation_cycle_ctrl: reset, sprinkler/drip runs, pause, abort,
// cooldown start-ignore, zero duration, async reset mid-run and the optional stats counter.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_irrigation_cycle_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  irrigation_cycle_ctrl_if #(.W(4)) bus ();

  irrigation_cycle_ctrl #(.W(4), .COOLDOWN_TICKS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic start_cycle(input logic m, input logic [3:0] d);
    bus.mode = m;
    if (m) bus.dur_drip = d;
    else   bus.dur_spr  = d;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tick = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
    bus.dur_spr = 4'd0; bus.dur_drip = 4'd0; bus.tank_low = 1'b0; bus.abort = 1'b0;
    #12;
    n_tests++;
    if ({bus.spr_count, bus.drip_count} !== 8'h00) begin
      n_fail++; $display("FAIL reset_counts: got %h expected 00", {bus.spr_count, bus.drip_count});
    end
    n_tests++;
    if ({bus.disp_sel, bus.valve_spr, bus.valve_drip, bus.busy, bus.done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                         {bus.disp_sel, bus.valve_spr, bus.valve_drip, bus.busy, bus.done});
    end
    n_tests++;
    if (bus.cycles_done !== 4'd0) begin
      n_fail++; $display("FAIL reset_cycles: got %0d expected 0", bus.cycles_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sprinkler();
    logic [3:0] exp;
    start_cycle(1'b0, 4'd5);
    n_tests++;
    if ({bus.valve_spr, bus.valve_drip, bus.busy, bus.disp_sel} !== 4'b1010) begin
      n_fail++; $display("FAIL spr_start_flags: got %b expected 1010",
                         {bus.valve_spr, bus.valve_drip, bus.busy, bus.disp_sel});
    end
    n_tests++;
    if (bus.spr_count !== 4'd5) begin
      n_fail++; $display("FAIL spr_start_count: got %0d expected 5", bus.spr_count);
    end
    for (int k = 1; k <= 5; k++) begin
      pulse_tick();
      exp = 4'(5 - k);
      n_tests++;
      if (bus.spr_count !== exp) begin
        n_fail++; $display("FAIL spr_count_tick%0d: got %0d expected %0d", k, bus.spr_count, exp);
      end
      n_tests++;
      if ({bus.valve_spr, bus.done} !== {(k < 5), (k == 5)}) begin
        n_fail++; $display("FAIL spr_valve_done_tick%0d: got %b expected %b", k,
                           {bus.valve_spr, bus.done}, {(k < 5), (k == 5)});
      end
    end
    step();
    n_tests++;
    if ({bus.done, bus.busy} !== 2'b01) begin
      n_fail++; $display("FAIL spr_done_width: got %b expected 01", {bus.done, bus.busy});
    end
    for (int k = 1; k <= 3; k++) begin
      pulse_tick();
      n_tests++;
      if (bus.busy !== (k < 3)) begin
        n_fail++; $display("FAIL spr_cooldown_busy%0d: got %b expected %b", k, bus.busy, (k < 3));
      end
    end
  endtask

  task automatic test_drip();
    logic [3:0] exp;
    start_cycle(1'b1, 4'd9);
    n_tests++;
    if ({bus.disp_sel, bus.drip_count, bus.spr_count} !== {1'b1, 4'd9, 4'd0}) begin
      n_fail++; $display("FAIL drip_start: got sel=%b drip=%0d spr=%0d expected sel=1 drip=9 spr=0",
                         bus.disp_sel, bus.drip_count, bus.spr_count);
    end
    for (int k = 1; k <= 9; k++) begin
      n_tests++;
      if ({bus.valve_spr, bus.valve_drip} !== 2'b01) begin
        n_fail++; $display("FAIL drip_valves_step%0d: got %b expected 01", k, {bus.valve_spr, bus.valve_drip});
      end
      pulse_tick();
      exp = 4'(9 - k);
      n_tests++;
      if ({bus.drip_count, bus.spr_count} !== {exp, 4'd0}) begin
        n_fail++; $display("FAIL drip_count_tick%0d: got drip=%0d spr=%0d expected drip=%0d spr=0",
                           k, bus.drip_count, bus.spr_count, exp);
      end
    end
    n_tests++;
    if ({bus.valve_drip, bus.done, bus.busy} !== 3'b011) begin
      n_fail++; $display("FAIL drip_end: got %b expected 011", {bus.valve_drip, bus.done, bus.busy});
    end
    for (int k = 0; k < 3; k++) pulse_tick();
    n_tests++;
    if ({bus.busy, bus.disp_sel} !== 2'b01) begin
      n_fail++; $display("FAIL drip_idle_hold_sel: got %b expected 01", {bus.busy, bus.disp_sel});
    end
  endtask

  task automatic test_pause();
    start_cycle(1'b1, 4'd9);
    for (int k = 0; k < 3; k++) pulse_tick();
    bus.tank_low = 1'b1;
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    n_tests++;
    if ({bus.drip_count, bus.valve_drip, bus.busy} !== {4'd6, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL pause_coincident_tick: got drip=%0d valve=%b busy=%b expected 6 0 1",
                         bus.drip_count, bus.valve_drip, bus.busy);
    end
    for (int k = 0; k < 2; k++) begin
      pulse_tick();
      n_tests++;
      if ({bus.drip_count, bus.valve_drip} !== {4'd6, 1'b0}) begin
        n_fail++; $display("FAIL pause_hold%0d: got drip=%0d valve=%b expected 6 0", k,
                           bus.drip_count, bus.valve_drip);
      end
    end
    bus.tank_low = 1'b0;
    step();
    n_tests++;
    if ({bus.drip_count, bus.valve_drip} !== {4'd6, 1'b1}) begin
      n_fail++; $display("FAIL pause_resume: got drip=%0d valve=%b expected 6 1", bus.drip_count, bus.valve_drip);
    end
    pulse_tick();
    n_tests++;
    if (bus.drip_count !== 4'd5) begin
      n_fail++; $display("FAIL pause_after_resume: got %0d expected 5", bus.drip_count);
    end
    for (int k = 0; k < 5; k++) pulse_tick();
    n_tests++;
    if ({bus.drip_count, bus.done} !== {4'd0, 1'b1}) begin
      n_fail++; $display("FAIL pause_complete: got drip=%0d done=%b expected 0 1", bus.drip_count, bus.done);
    end
    for (int k = 0; k < 3; k++) pulse_tick();
  endtask

  task automatic test_abort();
    start_cycle(1'b0, 4'd5);
    for (int k = 0; k < 3; k++) pulse_tick();
    n_tests++;
    if (bus.spr_count !== 4'd2) begin
      n_fail++; $display("FAIL abort_pre: got %0d expected 2", bus.spr_count);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_tests++;
    if ({bus.spr_count, bus.drip_count, bus.valve_spr, bus.valve_drip, bus.busy, bus.done} !== 12'b0) begin
      n_fail++; $display("FAIL abort_idle: got spr=%0d drip=%0d vs=%b vd=%b busy=%b done=%b expected all 0",
                         bus.spr_count, bus.drip_count, bus.valve_spr, bus.valve_drip, bus.busy, bus.done);
    end
    pulse_tick();
    n_tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL abort_no_cooldown: got %b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_cooldown_start();
    start_cycle(1'b0, 4'd1);
    pulse_tick();
    n_tests++;
    if ({bus.done, bus.busy} !== 2'b11) begin
      n_fail++; $display("FAIL cd_enter: got %b expected 11", {bus.done, bus.busy});
    end
    bus.mode = 1'b1;
    bus.dur_drip = 4'd7;
    bus.start = 1'b1;
    step();
    n_tests++;
    if ({bus.busy, bus.disp_sel, bus.drip_count, bus.valve_drip} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL cd_start_ignored: got busy=%b sel=%b drip=%0d vd=%b expected 1 0 0 0",
                         bus.busy, bus.disp_sel, bus.drip_count, bus.valve_drip);
    end
    pulse_tick();
    pulse_tick();
    bus.start = 1'b0;
    n_tests++;
    if ({bus.busy, bus.disp_sel} !== 2'b10) begin
      n_fail++; $display("FAIL cd_start_ignored2: got %b expected 10", {bus.busy, bus.disp_sel});
    end
    pulse_tick();
    n_tests++;
    if ({bus.busy, bus.valve_drip} !== 2'b00) begin
      n_fail++; $display("FAIL cd_exit: got %b expected 00", {bus.busy, bus.valve_drip});
    end
  endtask

  task automatic test_zero_dur();
    start_cycle(1'b0, 4'd0);
    n_tests++;
    if ({bus.done, bus.valve_spr, bus.busy, bus.spr_count} !== {3'b100, 4'd0}) begin
      n_fail++; $display("FAIL zero_dur: got done=%b vs=%b busy=%b spr=%0d expected 1 0 0 0",
                         bus.done, bus.valve_spr, bus.busy, bus.spr_count);
    end
    step();
    n_tests++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL zero_dur_after: got %b expected 00", {bus.done, bus.busy});
    end
  endtask

  task automatic test_tank_low_start();
    bus.tank_low = 1'b1;
    start_cycle(1'b0, 4'd5);
    bus.tank_low = 1'b0;
    n_tests++;
    if ({bus.busy, bus.valve_spr, bus.spr_count} !== {2'b00, 4'd0}) begin
      n_fail++; $display("FAIL tank_low_start: got busy=%b vs=%b spr=%0d expected 0 0 0",
                         bus.busy, bus.valve_spr, bus.spr_count);
    end
  endtask

  task automatic test_reset_mid_run();
    start_cycle(1'b1, 4'd5);
    pulse_tick();
    n_tests++;
    if ({bus.valve_drip, bus.drip_count} !== {1'b1, 4'd4}) begin
      n_fail++; $display("FAIL rst_mid_pre: got vd=%b drip=%0d expected 1 4", bus.valve_drip, bus.drip_count);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.valve_drip, bus.valve_spr, bus.busy, bus.disp_sel, bus.done} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b expected 00000",
                         {bus.valve_drip, bus.valve_spr, bus.busy, bus.disp_sel, bus.done});
    end
    n_tests++;
    if ({bus.drip_count, bus.spr_count, bus.cycles_done} !== 12'h000) begin
      n_fail++; $display("FAIL rst_mid_counts: got drip=%0d spr=%0d cyc=%0d expected 0 0 0",
                         bus.drip_count, bus.spr_count, bus.cycles_done);
    end
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stats();
    logic [3:0] exp;
`ifdef IRRIG_CYCLE_STATS_EN
    start_cycle(1'b0, 4'd3);
    pulse_tick();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_tests++;
    if (bus.cycles_done !== 4'd0) begin
      n_fail++; $display("FAIL stats_abort: got %0d expected 0", bus.cycles_done);
    end
    for (int i = 1; i <= 17; i++) begin
      start_cycle(1'b0, 4'd1);
      pulse_tick();
      exp = (i > 15) ? 4'd15 : 4'(i);
      n_tests++;
      if (bus.cycles_done !== exp) begin
        n_fail++; $display("FAIL stats_cycle%0d: got %0d expected %0d", i, bus.cycles_done, exp);
      end
      for (int k = 0; k < 3; k++) pulse_tick();
    end
    start_cycle(1'b0, 4'd0);
    n_tests++;
    if (bus.cycles_done !== 4'd15) begin
      n_fail++; $display("FAIL stats_zero_dur: got %0d expected 15", bus.cycles_done);
    end
`else
    exp = 4'd0;
    start_cycle(1'b0, 4'd1);
    pulse_tick();
    n_tests++;
    if ({bus.done, bus.cycles_done} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL stats_disabled: got done=%b cyc=%0d expected 1 0", bus.done, bus.cycles_done);
    end
    for (int k = 0; k < 3; k++) pulse_tick();
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sprinkler();
    test_drip();
    test_pause();
    test_abort();
    test_cooldown_start();
    test_zero_dur();
    test_tank_low_start();
    test_reset_mid_run();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
